mpmc11_strm_read_ctrl: RTL and testbench
========================================

MPMC11_STRM_READ_CTRL -- requirements
Module: mpmc11_strm_read_ctrl

Interface
REQ-001 SHALL have parameter MAX_OUT, default 16: maximum outstanding strip read commands.
REQ-002 SHALL have parameter FIFO_DEPTH, default 256: stream read FIFO write depth in entries.
REQ-003 SHALL have parameter CREDIT_MARGIN, default 8: slack for wr_count staleness.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is clocked on posedge clk.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1: stream request strobe.
REQ-007 SHALL have port req_ready, output, 1: high only in IDLE.
REQ-008 SHALL have port req_adr, input, 32: start byte address, 32-byte aligned; low 5 bits ignored.
REQ-009 SHALL have port req_len, input, 16: strip count, where one strip is 32 bytes.
REQ-010 SHALL have port abort, input, 1: cancel the active stream.
REQ-011 SHALL have port cmd_valid, output, 1: memory read command valid.
REQ-012 SHALL have port cmd_ready, input, 1: memory accepts the command.
REQ-013 SHALL have port cmd_adr, output, 32: strip byte address.
REQ-014 SHALL have port rd_valid, input, 1: in-order read data return.
REQ-015 SHALL have port rd_dat, input, WIDX8: returned strip data.
REQ-016 SHALL have port fifo_wr_count, input, 9: write-domain occupancy of the stream read FIFO.
REQ-017 SHALL have port wr, output, 1: stream read FIFO write strobe.
REQ-018 SHALL have port wdat, output, WIDX8: FIFO write data.
REQ-019 SHALL have port last_strip, output, 1: qualifies the final strip, valid with wr.
REQ-020 SHALL have port busy, output, 1: high whenever not in IDLE.
REQ-021 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-022 SHALL have port done_err, output, 1: one-cycle pulse with done when the stream was aborted.

Function
REQ-023 SHALL implement FSM states IDLE, ISSUE, DRAIN, FINISH.
REQ-024 SHALL latch req_adr[31:5], req_len and clear counters in IDLE on req_valid; next state is ISSUE, or FINISH if req_len==0.
REQ-025 SHALL, in ISSUE, assert cmd_valid iff issued<len and outstanding<MAX_OUT and outstanding+fifo_wr_count < FIFO_DEPTH-CREDIT_MARGIN.
REQ-026 SHALL drive cmd_adr = {base+issued, 5'b0}, wrapping modulo 2^32.
REQ-027 SHALL hold cmd_adr stable while cmd_valid is high and cmd_ready is low.
REQ-028 SHALL count a command issued on cmd_valid&cmd_ready, incrementing issued and outstanding.
REQ-029 SHALL decrement outstanding and increment received on rd_valid with outstanding>0.
REQ-030 SHALL leave outstanding unchanged when a command is issued and data returns in the same cycle.
REQ-031 SHALL ignore rd_valid when outstanding==0: no write, no count change.
REQ-032 SHALL register FIFO writes, so wr/wdat follow an accepted rd_valid by 1 cycle; wdat = rd_dat.
REQ-033 SHALL assert last_strip with wr iff the strip is number len-1 of a non-aborted stream; last_strip is 0 otherwise.
REQ-034 SHALL move ISSUE->DRAIN when issued==len.
REQ-035 SHALL move DRAIN->FINISH when outstanding==0, including the cycle the final rd_valid is consumed.
REQ-036 SHALL, in FINISH, pulse done for 1 cycle and return to IDLE; done occurs 1 cycle after the final wr.
REQ-037 SHALL handle abort in ISSUE or DRAIN as follows: stop issuing immediately (cmd_valid low that cycle), go to DRAIN, discard remaining returns (no wr), then FINISH with done_err=1.
REQ-038 SHALL ignore abort in IDLE and FINISH.
REQ-039 SHALL ignore req_valid while busy.

Reset
REQ-040 SHALL, on rst, enter IDLE, clear all counters, and drive cmd_valid, wr, last_strip, busy, done, done_err = 0; wdat and cmd_adr = 0 and req_ready = 1 from the first cycle after reset.
REQ-041 SHALL treat rst mid-stream as the only flush: outstanding returns after reset are ignored per REQ-031.

Verification
REQ-042 SHALL be verified with req_adr=0x1000, len=4, cmd_ready=1, data returned 2 cycles after each command -> cmd_adr 0x1000, 0x1020, 0x1040, 0x1060; 4 wr; last_strip on the 4th only; done 1 cycle later with done_err=0.
REQ-043 SHALL be verified with len=0 -> no cmd_valid, no wr; done pulses 2 cycles after req_valid.
REQ-044 SHALL be verified with fifo_wr_count=248 held and len=8 -> cmd_valid stays low; after dropping fifo_wr_count to 0, 8 commands issue and outstanding never exceeds 16.
REQ-045 SHALL be verified with req_adr=0xFFFFFFE0, len=2 -> cmd_adr 0xFFFFFFE0 then 0x00000000.
REQ-046 SHALL be verified with len=10, abort after 3 commands accepted and 1 returned -> no further cmd_valid; exactly 1 wr and no last_strip; done+done_err after 2 more returns.
REQ-047 SHALL be verified with rst asserted mid-DRAIN with 2 outstanding -> next cycle IDLE with all outputs per REQ-040; the 2 late rd_valid produce no wr.

Source files
------------

// File: rtl/mpmc11_strm_read_ctrl.sv
// Stream read controller: splits a strip request into 32-byte read commands,
// bounds in-flight reads by FIFO credit and forwards in-order returns to the FIFO.
module mpmc11_strm_read_ctrl #(
   parameter int MAX_OUT       = 16,
   parameter int FIFO_DEPTH    = 256,
   parameter int CREDIT_MARGIN = 8,
   parameter int WID           = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_adr,
   input  logic [15:0]      req_len,
   input  logic             abort,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic [31:0]      cmd_adr,
   input  logic             rd_valid,
   input  logic [WID*8-1:0] rd_dat,
   input  logic [8:0]       fifo_wr_count,
   output logic             wr,
   output logic [WID*8-1:0] wdat,
   output logic             last_strip,
   output logic             busy,
   output logic             done,
   output logic             done_err
);

   localparam int OW = $clog2(MAX_OUT + 1);
   localparam logic [31:0] OUT_LIM  = 32'(MAX_OUT);
   localparam logic [31:0] CRED_LIM = 32'(FIFO_DEPTH - CREDIT_MARGIN);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

   state_t        state, state_nxt;
   logic [26:0]   base;
   logic [15:0]   len, issued, issued_nxt, received;
   logic [OW-1:0] outstanding, out_nxt;
   logic          aborted, active, abort_now, abort_eff;
   logic          issue, rd_acc, credit_ok, adr_unused;

   // Strip addresses are 32-byte aligned, so the low address bits carry nothing
   assign adr_unused = ^req_adr[4:0];

   assign active     = (state == ISSUE) || (state == DRAIN);
   assign abort_now  = abort && active;
   assign abort_eff  = aborted || abort_now;
   assign rd_acc     = rd_valid && (outstanding != '0);
   assign req_ready  = (state == IDLE);
   assign busy       = (state != IDLE);
   assign cmd_adr    = {base + 27'(issued), 5'b0};

   assign credit_ok  = (32'(outstanding) < OUT_LIM) &&
                       (32'(outstanding) + 32'(fifo_wr_count) < CRED_LIM);
   assign cmd_valid  = (state == ISSUE) && !abort && (issued < len) && credit_ok;
   assign issue      = cmd_valid && cmd_ready;
   assign issued_nxt = issued + 16'(issue);

   always_comb begin
      out_nxt = outstanding;
      if (issue && !rd_acc)
         out_nxt = outstanding + 1'b1;
      else if (!issue && rd_acc)
         out_nxt = outstanding - 1'b1;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:
            if (req_valid)
               state_nxt = (req_len == 16'd0) ? FINISH : ISSUE;
         ISSUE:
            if (abort || (issued_nxt == len))
               state_nxt = DRAIN;
         DRAIN:
            if (out_nxt == '0)
               state_nxt = FINISH;
         FINISH:
            state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         base        <= '0;
         len         <= '0;
         issued      <= '0;
         received    <= '0;
         outstanding <= '0;
         aborted     <= 1'b0;
         wr          <= 1'b0;
         wdat        <= '0;
         last_strip  <= 1'b0;
         done        <= 1'b0;
         done_err    <= 1'b0;
      end else begin
         state       <= state_nxt;
         outstanding <= out_nxt;
         wr          <= rd_acc && !abort_eff;
         last_strip  <= rd_acc && !abort_eff && (received == len - 16'd1);
         done        <= (state == FINISH);
         done_err    <= (state == FINISH) && aborted;
         if (rd_acc)
            wdat <= rd_dat;
         if ((state == IDLE) && req_valid) begin
            base     <= req_adr[31:5];
            len      <= req_len;
            issued   <= '0;
            received <= '0;
            aborted  <= 1'b0;
         end else begin
            issued <= issued_nxt;
            if (rd_acc)
               received <= received + 16'd1;
            if (abort_now)
               aborted <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mpmc11_strm_read_ctrl.sv
// Bench for mpmc11_strm_read_ctrl: stream table plus credit, abort and reset
// sequences, with a memory responder and a FIFO-write scoreboard.
module tb_mpmc11_strm_read_ctrl;

   localparam int DW = 256;

   logic          clk = 1'b0;
   logic          rst, req_valid, req_ready, abort;
   logic          cmd_valid, cmd_ready, rd_valid;
   logic          wr, last_strip, busy, done, done_err;
   logic [31:0]   req_adr, cmd_adr;
   logic [15:0]   req_len;
   logic [DW-1:0] rd_dat, wdat;
   logic [8:0]    fifo_wr_count;

   always #5 clk = ~clk;

   mpmc11_strm_read_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_adr(req_adr), .req_len(req_len), .abort(abort),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr),
      .rd_valid(rd_valid), .rd_dat(rd_dat), .fifo_wr_count(fifo_wr_count),
      .wr(wr), .wdat(wdat), .last_strip(last_strip),
      .busy(busy), .done(done), .done_err(done_err)
   );

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } exp_t;

   typedef struct {
      logic [31:0] adr;
      int          len;
      logic [31:0] a0;
      logic [31:0] alast;
      int          ncmd;
      int          nwr;
      int          nlast;
   } vec_t;

   exp_t        sb[$];
   logic [31:0] resp_adr[$];
   int          resp_due[$];
   vec_t        tbl[6];

   int checks = 0, errors = 0, cyc = 0;
   bit ret_hold = 0, b_active = 0, b_abort = 0;
   logic [31:0] b_base, first_adr, last_adr;
   int b_len, cmd_idx, ret_idx, b_out = 0, max_out;
   int n_cmd, n_wr, n_last, n_done, n_err, n_ret, abort_rets;
   int req_cyc, done_cyc, last_wr_cyc, last_ret_cyc;

   function automatic logic [DW-1:0] pat(input logic [31:0] a);
      return {8{a ^ 32'h5A5A_00C3}};
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic clr();
      n_cmd = 0; n_wr = 0; n_last = 0; n_done = 0; n_err = 0;
      n_ret = 0; abort_rets = 0; max_out = 0; last_wr_cyc = -1;
      first_adr = '0; last_adr = '0;
   endtask

   task automatic step();
      logic [31:0] a, ea;
      exp_t e;
      if (abort && b_active) b_abort = 1;
      if (rst) begin
         b_active = 0; b_out = 0; sb.delete();
      end
      rd_valid = 1'b0;
      if (!rst && !ret_hold && resp_due.size() > 0 && resp_due[0] <= cyc) begin
         a = resp_adr.pop_front();
         void'(resp_due.pop_front());
         rd_valid = 1'b1;
         rd_dat = pat(a);
         n_ret++;
         last_ret_cyc = cyc;
         if (b_out > 0) begin
            b_out--;
            if (b_abort) abort_rets++;
            else sb.push_back('{pat(a), ret_idx == b_len - 1});
            ret_idx++;
         end
      end
      #1;
      if (b_abort) chk("cmd_after_abort", cmd_valid, 0);
      if (cmd_valid && cmd_ready) begin
         ea = b_base + 32'(cmd_idx) * 32'd32;
         chk("cmd_adr", cmd_adr, ea);
         if (cmd_idx == 0) first_adr = cmd_adr;
         last_adr = cmd_adr;
         cmd_idx++; n_cmd++; b_out++;
         resp_adr.push_back(cmd_adr);
         resp_due.push_back(cyc + 2);
      end
      if (b_out > max_out) max_out = b_out;
      if (wr) begin
         n_wr++;
         last_wr_cyc = cyc;
         if (last_strip) n_last++;
         if (sb.size() == 0) chk("unexpected_wr", wr, 0);
         else begin
            e = sb.pop_front();
            chk("wdat", wdat, e.d);
            chk("last_strip", last_strip, e.l);
         end
      end
      chk("last_qual", last_strip & ~wr, 0);
      chk("err_qual", done_err & ~done, 0);
      if (done) begin
         n_done++; done_cyc = cyc;
         if (done_err) n_err++;
         b_active = 0;
      end
      if (req_valid && req_ready) begin
         b_active = 1; b_abort = 0;
         b_base = {req_adr[31:5], 5'b0};
         b_len = req_len; cmd_idx = 0; ret_idx = 0; req_cyc = cyc;
      end
      @(negedge clk);
      #1;
      cyc++;
   endtask

   task automatic start_stream(input logic [31:0] adr, input int len);
      req_adr = adr;
      req_len = 16'(len);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
   endtask

   task automatic run_until_done(input int budget);
      int start;
      start = n_done;
      for (int i = 0; i < budget && n_done == start; i++) step();
      chk("done_seen", n_done - start, 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_req_ready"}, req_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_cmd_valid"}, cmd_valid, 0);
      chk({tag, "_wr"}, wr, 0);
      chk({tag, "_last"}, last_strip, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_done_err"}, done_err, 0);
      chk({tag, "_wdat"}, wdat, 0);
      chk({tag, "_cmd_adr"}, cmd_adr, 0);
   endtask

   initial begin
      tbl[0] = '{32'h0000_1000, 4,  32'h0000_1000, 32'h0000_1060, 4,  4,  1};
      tbl[1] = '{32'hFFFF_FFE0, 2,  32'hFFFF_FFE0, 32'h0000_0000, 2,  2,  1};
      tbl[2] = '{32'h0000_2017, 3,  32'h0000_2000, 32'h0000_2040, 3,  3,  1};
      tbl[3] = '{32'h8000_0000, 1,  32'h8000_0000, 32'h8000_0000, 1,  1,  1};
      tbl[4] = '{32'h1234_5660, 20, 32'h1234_5660, 32'h1234_58C0, 20, 20, 1};
      tbl[5] = '{32'h0000_0500, 0,  32'h0,         32'h0,         0,  0,  0};

      rst = 1; req_valid = 0; req_adr = '0; req_len = '0; abort = 0;
      cmd_ready = 1; rd_valid = 0; rd_dat = '0; fifo_wr_count = '0;
      @(negedge clk);
      #1;
      step();
      step();
      rst = 0;
      check_idle_outputs("reset");

      abort = 1;
      step();
      abort = 0;

      for (int i = 0; i < 6; i++) begin
         clr();
         start_stream(tbl[i].adr, tbl[i].len);
         run_until_done(200);
         chk("ncmd", n_cmd, tbl[i].ncmd);
         chk("nwr", n_wr, tbl[i].nwr);
         chk("nlast", n_last, tbl[i].nlast);
         chk("no_err", n_err, 0);
         chk("sb_empty", sb.size(), 0);
         if (tbl[i].ncmd > 0) begin
            chk("first_adr", first_adr, tbl[i].a0);
            chk("last_adr", last_adr, tbl[i].alast);
            chk("done_after_wr", done_cyc, last_wr_cyc + 1);
         end else begin
            chk("done_len0", done_cyc, req_cyc + 2);
         end
      end

      clr();
      fifo_wr_count = 9'd248;
      start_stream(32'h0000_4000, 8);
      repeat (5) step();
      req_adr = 32'h0000_9000; req_len = 16'd1; req_valid = 1;
      step();
      req_valid = 0;
      repeat (5) step();
      chk("credit_block", n_cmd, 0);
      chk("busy_blocked", busy, 1);
      fifo_wr_count = 9'd0;
      run_until_done(200);
      chk("credit_ncmd", n_cmd, 8);
      chk("credit_nwr", n_wr, 8);
      chk("credit_last", n_last, 1);
      chk("credit_maxout", max_out <= 16, 1);

      clr();
      ret_hold = 1;
      fifo_wr_count = 9'd240;
      start_stream(32'h0000_6000, 20);
      repeat (20) step();
      chk("credit_limit", n_cmd, 8);
      fifo_wr_count = 9'd0;
      repeat (20) step();
      chk("max_out_limit", n_cmd, 16);
      chk("max_out_peak", max_out, 16);
      ret_hold = 0;
      run_until_done(200);
      chk("limit_ncmd", n_cmd, 20);
      chk("limit_nwr", n_wr, 20);
      chk("limit_last", n_last, 1);

      clr();
      cmd_ready = 0;
      ret_hold = 1;
      start_stream(32'h0000_7000, 10);
      cmd_ready = 1;
      for (int i = 0; i < 20 && n_cmd < 3; i++) step();
      cmd_ready = 0;
      ret_hold = 0;
      for (int i = 0; i < 20 && n_ret < 1; i++) step();
      ret_hold = 1;
      step();
      chk("pre_abort_wr", n_wr, 1);
      abort = 1;
      cmd_ready = 1;
      step();
      abort = 0;
      ret_hold = 0;
      run_until_done(50);
      chk("abort_ncmd", n_cmd, 3);
      chk("abort_nwr", n_wr, 1);
      chk("abort_last", n_last, 0);
      chk("abort_err", n_err, 1);
      chk("abort_drops", abort_rets, 2);
      chk("abort_done_time", done_cyc, last_ret_cyc + 2);

      clr();
      ret_hold = 1;
      start_stream(32'h0000_A000, 2);
      for (int i = 0; i < 20 && n_cmd < 2; i++) step();
      step();
      chk("drain_busy", busy, 1);
      rst = 1;
      step();
      rst = 0;
      check_idle_outputs("midrst");
      ret_hold = 0;
      repeat (6) step();
      chk("late_rets", n_ret, 2);
      chk("late_no_wr", n_wr, 0);

      clr();
      start_stream(32'h0000_1000, 4);
      run_until_done(100);
      chk("recover_nwr", n_wr, 4);
      chk("recover_last", n_last, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
